// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI target: FSM states, frame widths, SPI mode
// and the bit positions of the peripheral status register.
package spi_slave_pkg;

  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  localparam int FRAME_W8  = 8;
  localparam int FRAME_W16 = 16;

  // Status register layout: {abort, underrun, overrun, rx_full, tx_full, busy}
  localparam int STAT_BUSY     = 0;
  localparam int STAT_TX_FULL  = 1;
  localparam int STAT_RX_FULL  = 2;
  localparam int STAT_OVERRUN  = 3;
  localparam int STAT_UNDERRUN = 4;
  localparam int STAT_ABORT    = 5;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } spi_state_e;

  // Bit-counter value of the last bit in a frame of the selected width.
  function automatic logic [4:0] frame_last(input logic wide);
    return wide ? 5'(FRAME_W16 - 1) : 5'(FRAME_W8 - 1);
  endfunction

endpackage

// File: rtl/spi_slave_if.sv
// Register-side and pin-side signals of the SPI target, with modports for the
// target itself (slave) and for whatever drives it (master).
interface spi_slave_if;
  // tx_write, rx_read and clear_flags are single-cycle strobes acted on at the
  // rising raw_clk edge where they are high; there is no back-pressure, so the
  // status bits (tx_full, rx_full) are the only flow control. rx_valid is a
  // single-cycle strobe coincident with the data_rx update.
  logic        width_16;
  logic [15:0] data_tx;
  logic        tx_write;
  logic        tx_full;
  logic [15:0] data_rx;
  logic        rx_valid;
  logic        rx_full;
  logic        rx_read;
  logic        overrun;
  logic        underrun;
  logic        abort;
  logic        clear_flags;
  logic        busy;
  logic        sclk;
  logic        mosi;
  logic        cs_n;
  logic        miso;
  logic        miso_oe;

  modport slave (
    input  width_16, data_tx, tx_write, rx_read, clear_flags, sclk, mosi, cs_n,
    output tx_full, data_rx, rx_valid, rx_full, overrun, underrun, abort,
           busy, miso, miso_oe
  );

  modport master (
    output width_16, data_tx, tx_write, rx_read, clear_flags, sclk, mosi, cs_n,
    input  tx_full, data_rx, rx_valid, rx_full, overrun, underrun, abort,
           busy, miso, miso_oe
  );
endinterface

// File: rtl/spi_slave_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin, plus rise/fall detect
// against one extra delay flop behind the last stage.
module spi_slave_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain  <= {STAGES{RESET_VAL}};
      last_q <= RESET_VAL;
    end else begin
      chain  <= {chain[STAGES-2:0], d};
      last_q <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = chain[STAGES-1] & ~last_q;
  assign fall = ~chain[STAGES-1] & last_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 target with 8/16-bit frames, oversampled on raw_clk. Holds one
// TX word ahead of the shifter and one received word, with sticky error flags.
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter logic MISO_IDLE   = 1'b1
) (
  input  logic       raw_clk,
  input  logic       reset_n,
  spi_slave_if.slave bus,
  output spi_state_e state
);

  spi_state_e  state_q, state_d;

  logic        cs_q, cs_rise, cs_fall;
  logic        sclk_rise, sclk_fall;
  logic        mosi_q;
  logic        unused_sclk_level, unused_mosi_rise, unused_mosi_fall;

  logic        frame16;
  logic [4:0]  bit_cnt;
  logic [14:0] rx_shift;
  logic [15:0] tx_shift;
  logic [15:0] hold;
  logic        reload_pending;
  logic        reload_empty;

  logic        tx_full_q, rx_full_q, rx_valid_q;
  logic        overrun_q, underrun_q, abort_q;
  logic [15:0] data_rx_q;

  logic        start_evt, end_evt, shift_in, shift_out, reload_evt, load_evt;
  logic        last_bit, frame_done, abort_evt, underrun_evt, overrun_evt;
  logic        busy_c, miso_c;

  spi_slave_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(raw_clk), .rst_n(reset_n), .d(bus.sclk),
    .q(unused_sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_slave_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(raw_clk), .rst_n(reset_n), .d(bus.mosi),
    .q(mosi_q), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
  );

  spi_slave_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(raw_clk), .rst_n(reset_n), .d(bus.cs_n),
    .q(cs_q), .rise(cs_rise), .fall(cs_fall)
  );

  always_ff @(posedge raw_clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (cs_fall) state_d = ST_SHIFT;
      ST_SHIFT: if (cs_rise) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // cs_n rising beats any sclk edge seen in the same cycle.
  always_comb begin
    start_evt    = (state_q == ST_IDLE) && cs_fall;
    end_evt      = (state_q == ST_SHIFT) && cs_rise;
    shift_in     = (state_q == ST_SHIFT) && !cs_rise && sclk_rise;
    shift_out    = (state_q == ST_SHIFT) && !cs_rise && sclk_fall;
    reload_evt   = shift_out && reload_pending;
    load_evt     = start_evt || reload_evt;
    last_bit     = (bit_cnt == frame_last(frame16));
    frame_done   = shift_in && last_bit;
    abort_evt    = end_evt && (bit_cnt != 5'd0);
    underrun_evt = (start_evt && !tx_full_q) || (shift_in && reload_empty);
    overrun_evt  = frame_done && rx_full_q && !bus.rx_read;
    busy_c       = ~cs_q;
    miso_c       = busy_c ? (frame16 ? tx_shift[15] : tx_shift[7]) : MISO_IDLE;
  end

  always_ff @(posedge raw_clk or negedge reset_n) begin
    if (!reset_n) begin
      frame16  <= 1'b0;
      bit_cnt  <= 5'd0;
      rx_shift <= '0;
    end else if (start_evt || end_evt) begin
      if (start_evt) frame16 <= bus.width_16;
      bit_cnt  <= 5'd0;
      rx_shift <= '0;
    end else if (shift_in) begin
      bit_cnt  <= last_bit ? 5'd0 : bit_cnt + 5'd1;
      rx_shift <= last_bit ? '0 : {rx_shift[13:0], mosi_q};
    end
  end

  // The reload after a completed frame happens on the trailing sclk fall even
  // when the host is about to release cs_n; an empty reload is only reported
  // as underrun once the next frame actually clocks its first bit.
  always_ff @(posedge raw_clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_shift       <= '0;
      reload_pending <= 1'b0;
      reload_empty   <= 1'b0;
    end else begin
      if (load_evt)       tx_shift <= tx_full_q ? hold : {16{MISO_IDLE}};
      else if (shift_out) tx_shift <= {tx_shift[14:0], 1'b0};

      if (start_evt || end_evt) reload_pending <= 1'b0;
      else if (frame_done)      reload_pending <= 1'b1;
      else if (reload_evt)      reload_pending <= 1'b0;

      if (start_evt || end_evt) reload_empty <= 1'b0;
      else if (reload_evt)      reload_empty <= !tx_full_q;
      else if (shift_in)        reload_empty <= 1'b0;
    end
  end

  always_ff @(posedge raw_clk or negedge reset_n) begin
    if (!reset_n) begin
      hold      <= '0;
      tx_full_q <= 1'b0;
    end else if (bus.tx_write) begin
      hold      <= bus.data_tx;
      tx_full_q <= 1'b1;
    end else if (load_evt) begin
      tx_full_q <= 1'b0;
    end
  end

  always_ff @(posedge raw_clk or negedge reset_n) begin
    if (!reset_n) begin
      data_rx_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_full_q  <= 1'b0;
    end else begin
      rx_valid_q <= frame_done;
      if (frame_done)
        data_rx_q <= frame16 ? {rx_shift, mosi_q} : {8'h00, rx_shift[6:0], mosi_q};
      if (frame_done)       rx_full_q <= 1'b1;
      else if (bus.rx_read) rx_full_q <= 1'b0;
    end
  end

  always_ff @(posedge raw_clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      overrun_q  <= overrun_evt  | (overrun_q  & ~bus.clear_flags);
      underrun_q <= underrun_evt | (underrun_q & ~bus.clear_flags);
      abort_q    <= abort_evt    | (abort_q    & ~bus.clear_flags);
    end
  end

  assign bus.tx_full  = tx_full_q;
  assign bus.data_rx  = data_rx_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_full  = rx_full_q;
  assign bus.overrun  = overrun_q;
  assign bus.underrun = underrun_q;
  assign bus.abort    = abort_q;
  assign bus.busy     = busy_c;
  assign bus.miso     = miso_c;
  assign bus.miso_oe  = busy_c;
  assign state        = state_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a mode-0 host model drives the pins on raw_clk falling
// edges; received words are checked against an expected-data queue.
module tb_spi_slave;
  import spi_slave_pkg::*;

  logic       raw_clk = 1'b0;
  logic       reset_n;
  spi_state_e state;

  spi_slave_if bus();

  spi_slave #(.SYNC_STAGES(2), .MISO_IDLE(1'b1)) dut (
    .raw_clk(raw_clk),
    .reset_n(reset_n),
    .bus(bus),
    .state(state)
  );

  always #5 raw_clk = ~raw_clk;

  int          checks = 0;
  int          passed = 0;
  int          rx_valid_cnt = 0;
  logic [15:0] exp_q[$];
  logic [15:0] sb_exp;

  // Scoreboard: every rx_valid pops one expected word.
  always @(posedge raw_clk) begin
    #1;
    if (bus.rx_valid === 1'b1) begin
      rx_valid_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL rx_scoreboard: unexpected rx_valid, data_rx=%h", bus.data_rx);
      end else begin
        sb_exp = exp_q.pop_front();
        if (bus.data_rx !== sb_exp)
          $display("FAIL rx_scoreboard: data_rx=%h expected %h", bus.data_rx, sb_exp);
        else passed++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic host_wait(input int n);
    repeat (n) @(negedge raw_clk);
  endtask

  task automatic pulse_tx(input logic [15:0] d);
    bus.data_tx  = d;
    bus.tx_write = 1'b1;
    @(negedge raw_clk);
    bus.tx_write = 1'b0;
  endtask

  task automatic pulse_read();
    bus.rx_read = 1'b1;
    @(negedge raw_clk);
    bus.rx_read = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.clear_flags = 1'b1;
    @(negedge raw_clk);
    bus.clear_flags = 1'b0;
  endtask

  task automatic cs_low();
    bus.cs_n = 1'b0;
    host_wait(6);
  endtask

  task automatic cs_high();
    host_wait(4);
    bus.cs_n = 1'b1;
    host_wait(8);
  endtask

  // Sends word[nbits-1:0] MSB first; miso is sampled just before each rise.
  // With read_last set, rx_read is pulsed in the cycle the last bit completes.
  task automatic host_frame(input logic [15:0] word, input int nbits, input int hi,
                            input int lo, input bit read_last, output logic [15:0] got);
    got = '0;
    for (int i = nbits - 1; i >= 0; i--) begin
      bus.mosi = word[i];
      host_wait(lo);
      got = {got[14:0], bus.miso};
      bus.sclk = 1'b1;
      if (read_last && i == 0) begin
        host_wait(2);
        bus.rx_read = 1'b1;
        host_wait(1);
        bus.rx_read = 1'b0;
        host_wait(hi - 3);
      end else begin
        host_wait(hi);
      end
      bus.sclk = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.tx_full, bus.rx_full, bus.rx_valid} !== 3'b000)
      $display("FAIL reset_status: {tx_full,rx_full,rx_valid}=%b expected 000",
               {bus.tx_full, bus.rx_full, bus.rx_valid});
    else passed++;
    checks++;
    if (bus.data_rx !== 16'h0000) $display("FAIL reset_data_rx: got %h expected 0000", bus.data_rx);
    else passed++;
    checks++;
    if ({bus.abort, bus.underrun, bus.overrun} !== 3'b000)
      $display("FAIL reset_flags: got %b expected 000", {bus.abort, bus.underrun, bus.overrun});
    else passed++;
    checks++;
    if ({bus.busy, bus.miso_oe} !== 2'b00)
      $display("FAIL reset_busy: {busy,miso_oe}=%b expected 00", {bus.busy, bus.miso_oe});
    else passed++;
    checks++;
    if (bus.miso !== 1'b1) $display("FAIL reset_miso: got %b expected 1", bus.miso);
    else passed++;
    checks++;
    if (state !== ST_IDLE) $display("FAIL reset_state: got %0d expected IDLE", state);
    else passed++;
    host_wait(3);
    reset_n = 1'b1;
    host_wait(3);
  endtask

  task automatic test_basic_8();
    logic [15:0] got;
    int n0;
    bus.width_16 = 1'b0;
    pulse_tx(16'h00A5);
    checks++;
    if (bus.tx_full !== 1'b1) $display("FAIL basic_tx_full_load: got %b expected 1", bus.tx_full);
    else passed++;
    n0 = rx_valid_cnt;
    exp_q.push_back(16'h003C);
    cs_low();
    host_frame(16'h003C, 8, 4, 4, 1'b0, got);
    cs_high();
    checks++;
    if (got[7:0] !== 8'hA5) $display("FAIL basic_miso: got %h expected a5", got[7:0]);
    else passed++;
    checks++;
    if (rx_valid_cnt - n0 !== 1) $display("FAIL basic_rx_valid_count: got %0d expected 1", rx_valid_cnt - n0);
    else passed++;
    checks++;
    if ({bus.rx_full, bus.tx_full} !== 2'b10)
      $display("FAIL basic_status: {rx_full,tx_full}=%b expected 10", {bus.rx_full, bus.tx_full});
    else passed++;
    checks++;
    if ({bus.abort, bus.underrun, bus.overrun} !== 3'b000)
      $display("FAIL basic_flags: got %b expected 000", {bus.abort, bus.underrun, bus.overrun});
    else passed++;
    checks++;
    if ({bus.busy, bus.miso} !== 2'b01)
      $display("FAIL basic_idle_pins: {busy,miso}=%b expected 01", {bus.busy, bus.miso});
    else passed++;
    pulse_read();
    checks++;
    if (bus.rx_full !== 1'b0) $display("FAIL basic_rx_read: rx_full=%b expected 0", bus.rx_full);
    else passed++;
  endtask

  task automatic test_back_to_back_16();
    logic [15:0] g1, g2;
    int n0;
    bus.width_16 = 1'b1;
    pulse_tx(16'hBEEF);
    n0 = rx_valid_cnt;
    exp_q.push_back(16'h1234);
    exp_q.push_back(16'h5678);
    cs_low();
    host_frame(16'h1234, 16, 5, 5, 1'b0, g1);
    host_frame(16'h5678, 16, 5, 5, 1'b0, g2);
    cs_high();
    checks++;
    if (g1 !== 16'hBEEF) $display("FAIL b2b_miso_first: got %h expected beef", g1);
    else passed++;
    checks++;
    if (g2 !== 16'hFFFF) $display("FAIL b2b_miso_second: got %h expected ffff", g2);
    else passed++;
    checks++;
    if (bus.data_rx !== 16'h5678) $display("FAIL b2b_data_rx: got %h expected 5678", bus.data_rx);
    else passed++;
    checks++;
    if ({bus.abort, bus.underrun, bus.overrun} !== 3'b011)
      $display("FAIL b2b_flags: got %b expected 011", {bus.abort, bus.underrun, bus.overrun});
    else passed++;
    checks++;
    if (rx_valid_cnt - n0 !== 2) $display("FAIL b2b_rx_valid_count: got %0d expected 2", rx_valid_cnt - n0);
    else passed++;
    pulse_clear();
    checks++;
    if ({bus.abort, bus.underrun, bus.overrun} !== 3'b000)
      $display("FAIL b2b_clear_flags: got %b expected 000", {bus.abort, bus.underrun, bus.overrun});
    else passed++;
    pulse_read();
  endtask

  task automatic test_abort();
    logic [15:0] got;
    int n0;
    bus.width_16 = 1'b0;
    pulse_tx(16'h00F0);
    n0 = rx_valid_cnt;
    cs_low();
    host_frame(16'h0015, 5, 4, 4, 1'b0, got);
    cs_high();
    checks++;
    if ({bus.abort, bus.underrun, bus.overrun} !== 3'b100)
      $display("FAIL abort_flags: got %b expected 100", {bus.abort, bus.underrun, bus.overrun});
    else passed++;
    checks++;
    if (rx_valid_cnt - n0 !== 0) $display("FAIL abort_no_rx_valid: got %0d expected 0", rx_valid_cnt - n0);
    else passed++;
    checks++;
    if (bus.data_rx !== 16'h5678) $display("FAIL abort_data_kept: got %h expected 5678", bus.data_rx);
    else passed++;
    checks++;
    if (bus.busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", bus.busy);
    else passed++;
    checks++;
    if (state !== ST_IDLE) $display("FAIL abort_state: got %0d expected IDLE", state);
    else passed++;
    pulse_tx(16'h0042);
    exp_q.push_back(16'h0081);
    cs_low();
    host_frame(16'h0081, 8, 4, 4, 1'b0, got);
    cs_high();
    checks++;
    if (got[7:0] !== 8'h42) $display("FAIL abort_next_miso: got %h expected 42", got[7:0]);
    else passed++;
    checks++;
    if ({bus.abort, bus.underrun, bus.overrun} !== 3'b100)
      $display("FAIL abort_next_flags: got %b expected 100", {bus.abort, bus.underrun, bus.overrun});
    else passed++;
    pulse_clear();
    checks++;
    if (bus.abort !== 1'b0) $display("FAIL abort_clear: got %b expected 0", bus.abort);
    else passed++;
    pulse_read();
  endtask

  task automatic test_read_race();
    logic [15:0] got;
    int n0;
    bus.width_16 = 1'b0;
    pulse_tx(16'h0011);
    n0 = rx_valid_cnt;
    exp_q.push_back(16'h00A1);
    exp_q.push_back(16'h00B2);
    cs_low();
    host_frame(16'h00A1, 8, 5, 4, 1'b0, got);
    host_frame(16'h00B2, 8, 5, 4, 1'b1, got);
    cs_high();
    checks++;
    if (bus.overrun !== 1'b0) $display("FAIL race_overrun: got %b expected 0", bus.overrun);
    else passed++;
    checks++;
    if (bus.rx_full !== 1'b1) $display("FAIL race_rx_full: got %b expected 1", bus.rx_full);
    else passed++;
    checks++;
    if (rx_valid_cnt - n0 !== 2) $display("FAIL race_rx_valid_count: got %0d expected 2", rx_valid_cnt - n0);
    else passed++;
    pulse_clear();
    pulse_read();
  endtask

  task automatic test_async_reset();
    logic [15:0] got;
    bus.width_16 = 1'b0;
    pulse_tx(16'h00FF);
    cs_low();
    host_frame(16'h0005, 3, 4, 4, 1'b0, got);
    host_wait(2);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.tx_full, bus.rx_full, bus.rx_valid, bus.busy, bus.miso_oe} !== 5'b00000)
      $display("FAIL areset_status: {tx_full,rx_full,rx_valid,busy,miso_oe}=%b expected 00000",
               {bus.tx_full, bus.rx_full, bus.rx_valid, bus.busy, bus.miso_oe});
    else passed++;
    checks++;
    if (bus.data_rx !== 16'h0000) $display("FAIL areset_data_rx: got %h expected 0000", bus.data_rx);
    else passed++;
    checks++;
    if ({bus.abort, bus.underrun, bus.overrun} !== 3'b000)
      $display("FAIL areset_flags: got %b expected 000", {bus.abort, bus.underrun, bus.overrun});
    else passed++;
    checks++;
    if (bus.miso !== 1'b1) $display("FAIL areset_miso: got %b expected 1", bus.miso);
    else passed++;
    checks++;
    if (state !== ST_IDLE) $display("FAIL areset_state: got %0d expected IDLE", state);
    else passed++;
    bus.cs_n = 1'b1;
    bus.sclk = 1'b0;
    host_wait(3);
    reset_n = 1'b1;
    host_wait(3);
    pulse_tx(16'h003C);
    exp_q.push_back(16'h00C3);
    cs_low();
    host_frame(16'h00C3, 8, 4, 4, 1'b0, got);
    cs_high();
    checks++;
    if (got[7:0] !== 8'h3C) $display("FAIL areset_next_miso: got %h expected 3c", got[7:0]);
    else passed++;
    checks++;
    if (bus.rx_full !== 1'b1) $display("FAIL areset_next_rx_full: got %b expected 1", bus.rx_full);
    else passed++;
    checks++;
    if ({bus.abort, bus.underrun, bus.overrun} !== 3'b000)
      $display("FAIL areset_next_flags: got %b expected 000", {bus.abort, bus.underrun, bus.overrun});
    else passed++;
    pulse_read();
  endtask

  task automatic test_slow_host();
    logic [15:0] got, g;
    logic [7:0]  word;
    int n0, hi;
    bus.width_16 = 1'b0;
    word = 8'h5A;
    pulse_tx(16'h0096);
    n0 = rx_valid_cnt;
    exp_q.push_back(16'h005A);
    cs_low();
    got = '0;
    for (int i = 7; i >= 0; i--) begin
      hi = $urandom_range(8, 56);
      host_frame({15'b0, word[i]}, 1, hi, 64 - hi, 1'b0, g);
      got = {got[14:0], g[0]};
    end
    cs_high();
    checks++;
    if (got[7:0] !== 8'h96) $display("FAIL slow_miso: got %h expected 96", got[7:0]);
    else passed++;
    checks++;
    if (rx_valid_cnt - n0 !== 1) $display("FAIL slow_rx_valid_count: got %0d expected 1", rx_valid_cnt - n0);
    else passed++;
    checks++;
    if (bus.data_rx !== 16'h005A) $display("FAIL slow_data_rx: got %h expected 005a", bus.data_rx);
    else passed++;
    checks++;
    if ({bus.abort, bus.underrun, bus.overrun} !== 3'b000)
      $display("FAIL slow_flags: got %b expected 000", {bus.abort, bus.underrun, bus.overrun});
    else passed++;
    pulse_read();
  endtask

  initial begin
    bus.sclk        = 1'b0;
    bus.mosi        = 1'b0;
    bus.cs_n        = 1'b1;
    bus.width_16    = 1'b0;
    bus.data_tx     = 16'h0000;
    bus.tx_write    = 1'b0;
    bus.rx_read     = 1'b0;
    bus.clear_flags = 1'b0;
    reset_n         = 1'b1;
    @(negedge raw_clk);
    test_reset();
    test_basic_8();
    test_back_to_back_16();
    test_abort();
    test_read_race();
    test_async_reset();
    test_slow_host();
    host_wait(10);
    checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d words left, expected 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
